command_arbiter: RTL and testbench
==================================

# command_arbiter

Shares the single PSL command port among the AFU's command producers (WED fetch, CU read, CU write, prefetch read, prefetch write). It sits between the per-producer command buffers and the PSL command interface inside afu_control. It grants one producer per cycle: WED has strict priority and the rest are served round-robin. It tracks PSL command credits, assigns tags, bounds outstanding commands, and drains cleanly when the job stops.

## Interface
Parameters:
- NUM_REQ, 5, number of requesters; index 0 = WED (strict priority), 1..NUM_REQ-1 round-robin.
- TAG_W, 8, tag width.
- MAX_OUTSTANDING, 64, cap on issued-but-unanswered commands (≤ 2^TAG_W).
- CREDIT_W, 8, credit counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- enabled_in  in  1  job running.
- credits_init  in  CREDIT_W  PSL room value, sampled in LOAD.
- req_valid  in  NUM_REQ  requester has a command at its head.
- req_command  in  NUM_REQ × CommandBufferLine  head command per requester.
- req_pop  out  NUM_REQ  one-hot, 1-cycle pulse: head consumed.
- response_valid  in  1  PSL response strobe.
- response_tag  in  TAG_W  tag of the completed command.
- response_credits  in  9 (signed)  credits returned with the response.
- command_valid  out  1  command to PSL this cycle.
- command_out  out  CommandBufferLine  granted command, tag field overwritten.
- credits_out  out  CREDIT_W  current credit count.
- outstanding_out  out  TAG_W+1  issued-minus-responded count.
- state_out  out  2  FSM state encoding (debug/status).
- credit_overflow_error  out  1  sticky error.

## Operation
- FSM states: IDLE=0, LOAD=1, RUN=2, DRAIN=3.
  - IDLE→LOAD when enabled_in=1.
  - LOAD→RUN after one cycle; credits ← credits_init.
  - RUN→DRAIN when enabled_in=0.
  - DRAIN→IDLE when outstanding=0 and no command is pending.
- Grant is eligible only in RUN, with credits>0 and outstanding<MAX_OUTSTANDING.
  - If req_valid[0]=1, grant 0.
  - Otherwise grant the first valid index after rr_ptr (cyclic over 1..NUM_REQ-1). rr_ptr ← granted index; WED grants do not move rr_ptr.
- On grant:
  - req_pop[g]=1 the same cycle.
  - Command and tag are registered.
  - credits −1; outstanding +1; next_tag +1, wrapping mod 2^TAG_W.
- On response_valid: credits += response_credits; outstanding −1.
  - A response arriving while outstanding=0 is ignored.
  - response_tag is not checked against the tag sequence.
- Grant and response in the same cycle apply the net change: credits + response_credits − 1; outstanding unchanged.
- credit_overflow_error is set when the updated credits would exceed the value loaded in LOAD, or go below 0.
  - The credit value is then saturated to the nearest bound.
  - The error stays set until reset.
- DRAIN issues no grants but keeps accounting responses.
- Arithmetic is unsigned except response_credits, which is sign-extended to CREDIT_W+2 for the update.

## Timing
- Grant is combinational from registered state plus req_valid. req_pop is in cycle N; command_valid/command_out are registered and appear in N+1. Issue latency is 1.
- At most one command per cycle; back-to-back issue every cycle while credits last.
- credits_out and outstanding_out reflect updates one cycle after the causing event.
- Reset values: state=IDLE, credits=0, outstanding=0, next_tag=0, rr_ptr=NUM_REQ-1, command_valid=0, command_out=0, req_pop=0, credit_overflow_error=0.
- Reset mid-operation returns everything to reset values immediately; in-flight tags are forgotten.
- If enabled_in deasserts in the same cycle as a grant, the grant completes and its command issues; DRAIN begins next cycle.

## Structure
- Add to AFU_PKG: the arbiter_state_type enum (IDLE/LOAD/RUN/DRAIN) and the WED_REQ_INDEX=0 constant.
- CommandBufferLine stays in AFU_PKG unchanged.
- One sub-module, round_robin_priority_arbiter (NUM_REQ, masked request + pointer → one-hot grant), reused by other arbiters.

## Test plan
- **Priority:** credits_init=8, all five req_valid held high for 8 cycles → pop order 0,0,0… (WED only), 8 commands issued, credits_out=0, then no further pops.
- **Round-robin:** req_valid=5'b01110 held, credits_init=16 → grants 1,2,3,1,2,3…; tags 0,1,2,…
- **Credit return:** credits_init=2, req_valid[1]=1, responses return +1 each two cycles after issue → steady issue, credits never negative, no error.
- **Simultaneous grant and response:** credits=3, grant plus response_credits=+1 in the same cycle → credits stays 3, outstanding unchanged.
- **Overflow:** credits_init=4, idle, response with credits=+2 → credit_overflow_error=1, credits_out=4, error stays set until reset.
- **Drain and reset:** 3 outstanding, drop enabled_in → state DRAIN, no pops; 3 responses → IDLE. Repeat, asserting reset mid-DRAIN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/command_arbiter_pkg.sv
// Shared types for the PSL command arbiter: FSM state encoding, WED requester
// index and the command buffer line carried from producers to the PSL port.
package command_arbiter_pkg;

    localparam int unsigned WED_REQ_INDEX = 0;
    localparam int unsigned CMD_TAG_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } arbiter_state_type;

    typedef struct packed {
        logic [12:0]          command;
        logic [11:0]          size;
        logic [63:0]          address;
        logic [CMD_TAG_W-1:0] tag;
    } CommandBufferLine;

endpackage

// File: rtl/round_robin_priority_arbiter.sv
// Round-robin picker: grants the first requesting index strictly after
// pointer, wrapping cyclically over 0..NUM_REQ-1; output is one-hot or zero.
module round_robin_priority_arbiter #(
    parameter int unsigned NUM_REQ = 5
) (
    input  logic [NUM_REQ-1:0]         request,
    input  logic [$clog2(NUM_REQ)-1:0] pointer,
    output logic [NUM_REQ-1:0]         grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!found && request[k] && (k == (32'(pointer) + off) % NUM_REQ)) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/command_arbiter.sv
// Shares the PSL command port among AFU command producers: WED has strict
// priority, the rest round-robin; tracks credits, tags and outstanding count.
module command_arbiter
    import command_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 5,
    parameter int unsigned TAG_W           = 8,
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter int unsigned CREDIT_W        = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               enabled_in,
    input  logic [CREDIT_W-1:0]                credits_init,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  CommandBufferLine [NUM_REQ-1:0]     req_command,
    output logic [NUM_REQ-1:0]                 req_pop,
    input  logic                               response_valid,
    input  logic [TAG_W-1:0]                   response_tag,
    input  logic signed [8:0]                  response_credits,
    output logic                               command_valid,
    output CommandBufferLine                   command_out,
    output logic [CREDIT_W-1:0]                credits_out,
    output logic [TAG_W:0]                     outstanding_out,
    output logic [1:0]                         state_out,
    output logic                               credit_overflow_error
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned SUM_W = CREDIT_W + 2;
    localparam logic [NUM_REQ-1:0] WED_MASK = NUM_REQ'(1) << WED_REQ_INDEX;
    localparam logic [TAG_W:0] MAX_OUT = (TAG_W + 1)'(MAX_OUTSTANDING);
    localparam logic signed [SUM_W-1:0] CREDIT_ONE = 1;

    arbiter_state_type state;
    logic [CREDIT_W-1:0] credits;
    logic [CREDIT_W-1:0] credit_limit;
    logic [TAG_W:0]      outstanding;
    logic [TAG_W-1:0]    next_tag;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    grant_index;

    logic                eligible;
    logic                wed_grant;
    logic                grant_any;
    logic                resp_accept;
    logic [NUM_REQ-1:0]  rr_grant;
    logic [NUM_REQ-1:0]  grant;
    CommandBufferLine    issue_cmd;

    logic signed [SUM_W-1:0] credit_sum;
    logic                    credit_over;
    logic                    credit_under;
    logic [CREDIT_W-1:0]     credit_update;

    // Tags are not cross-checked against the issue sequence.
    logic unused_tag;
    assign unused_tag = ^response_tag;

    round_robin_priority_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .request(req_valid & ~WED_MASK),
        .pointer(rr_ptr),
        .grant  (rr_grant)
    );

    assign eligible    = !reset && (state == RUN) && (credits != '0) && (outstanding < MAX_OUT);
    assign wed_grant   = eligible && req_valid[WED_REQ_INDEX];
    assign resp_accept = response_valid && (outstanding != '0);

    always_comb begin
        grant = '0;
        if (wed_grant) begin
            grant = WED_MASK;
        end else if (eligible) begin
            grant = rr_grant;
        end
    end

    assign grant_any = |grant;
    assign req_pop   = grant;

    always_comb begin
        grant_index = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) grant_index = PTR_W'(k);
        end
        issue_cmd     = req_command[grant_index];
        issue_cmd.tag = CMD_TAG_W'(next_tag);
    end

    // Net credit change of a same-cycle grant and response, saturated to [0, loaded value].
    always_comb begin
        credit_sum = signed'({2'b00, credits});
        if (resp_accept) credit_sum = credit_sum + SUM_W'(response_credits);
        if (grant_any)   credit_sum = credit_sum - CREDIT_ONE;
        credit_under = credit_sum[SUM_W-1];
        credit_over  = !credit_under && (credit_sum > signed'({2'b00, credit_limit}));
        if (credit_under) begin
            credit_update = '0;
        end else if (credit_over) begin
            credit_update = credit_limit;
        end else begin
            credit_update = credit_sum[CREDIT_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state                 <= IDLE;
            credits               <= '0;
            credit_limit          <= '0;
            outstanding           <= '0;
            next_tag              <= '0;
            rr_ptr                <= PTR_W'(NUM_REQ - 1);
            command_valid         <= 1'b0;
            command_out           <= '0;
            credit_overflow_error <= 1'b0;
        end else begin
            command_valid <= grant_any;
            if (grant_any) begin
                command_out <= issue_cmd;
                next_tag    <= next_tag + 1'b1;
                if (!wed_grant) rr_ptr <= grant_index;
            end

            case ({grant_any, resp_accept})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            if (grant_any || resp_accept) begin
                credits <= credit_update;
                if (credit_over || credit_under) credit_overflow_error <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (enabled_in) state <= LOAD;
                end
                LOAD: begin
                    credits      <= credits_init;
                    credit_limit <= credits_init;
                    state        <= RUN;
                end
                RUN: begin
                    if (!enabled_in) state <= DRAIN;
                end
                DRAIN: begin
                    if ((outstanding == '0) && !command_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign credits_out     = credits;
    assign outstanding_out = outstanding;
    assign state_out       = state;

endmodule

// File: tb/tb_command_arbiter.sv
// Directed bench for command_arbiter: priority, round-robin, credit return,
// net grant+response, overflow, drain and mid-drain reset.
module tb_command_arbiter;
    import command_arbiter_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   enabled_in;
    logic [7:0]             credits_init;
    logic [4:0]             req_valid;
    CommandBufferLine [4:0] req_command;
    logic [4:0]             req_pop;
    logic                   response_valid;
    logic [7:0]             response_tag;
    logic signed [8:0]      response_credits;
    logic                   command_valid;
    CommandBufferLine       command_out;
    logic [7:0]             credits_out;
    logic [8:0]             outstanding_out;
    logic [1:0]             state_out;
    logic                   credit_overflow_error;

    int tests_run    = 0;
    int tests_failed = 0;

    command_arbiter #(
        .NUM_REQ(5),
        .TAG_W(8),
        .MAX_OUTSTANDING(64),
        .CREDIT_W(8)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .enabled_in           (enabled_in),
        .credits_init         (credits_init),
        .req_valid            (req_valid),
        .req_command          (req_command),
        .req_pop              (req_pop),
        .response_valid       (response_valid),
        .response_tag         (response_tag),
        .response_credits     (response_credits),
        .command_valid        (command_valid),
        .command_out          (command_out),
        .credits_out          (credits_out),
        .outstanding_out      (outstanding_out),
        .state_out            (state_out),
        .credit_overflow_error(credit_overflow_error)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        enabled_in       = 1'b0;
        credits_init     = '0;
        req_valid        = '0;
        response_valid   = 1'b0;
        response_credits = '0;
        response_tag     = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic start_job(input logic [7:0] c);
        enabled_in   = 1'b1;
        credits_init = c;
        cycle();
        cycle();
    endtask

    task automatic check_reset_values(input string pfx);
        settle();
        check({pfx, "_state"}, state_out, 0);
        check({pfx, "_credits"}, credits_out, 0);
        check({pfx, "_outstanding"}, outstanding_out, 0);
        check({pfx, "_cmd_valid"}, command_valid, 0);
        check({pfx, "_cmd_addr"}, command_out.address, 0);
        check({pfx, "_cmd_rest"}, {command_out.command, command_out.size, command_out.tag}, 0);
        check({pfx, "_pop"}, req_pop, 0);
        check({pfx, "_error"}, credit_overflow_error, 0);
    endtask

    logic [4:0]  rr_req  [9] = '{5'b01110, 5'b01110, 5'b01110, 5'b01111, 5'b01110,
                                 5'b01110, 5'b10110, 5'b10110, 5'b10110};
    logic [4:0]  rr_pop  [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b00001, 5'b00010,
                                 5'b00100, 5'b10000, 5'b00010, 5'b00100};
    logic [63:0] rr_addr [9] = '{64'h2000, 64'h3000, 64'h4000, 64'h1000, 64'h2000,
                                 64'h3000, 64'h5000, 64'h2000, 64'h3000};

    logic pop_hist [16];
    int   model_credits;
    logic exp_pop;
    logic resp_now;

    initial begin
        for (int p = 0; p < 5; p++) begin
            req_command[p].command = 13'h0A00 + 13'(p);
            req_command[p].size    = 12'd128;
            req_command[p].address = 64'h1000 * 64'(p + 1);
            req_command[p].tag     = 8'hFF;
        end

        // Priority: WED takes every slot while credits last
        do_reset();
        check_reset_values("rst");
        req_valid = 5'b11111;
        start_job(8'd8);
        for (int i = 0; i < 8; i++) begin
            settle();
            check("prio_pop", req_pop, 5'b00001);
            check("prio_credits", credits_out, 64'(8 - i));
            if (i > 0) begin
                check("prio_cmd_valid", command_valid, 1);
                check("prio_tag", command_out.tag, 64'(i - 1));
            end
            cycle();
        end
        settle();
        check("prio_exhausted_pop", req_pop, 0);
        check("prio_last_tag", command_out.tag, 7);
        check("prio_last_addr", command_out.address, 64'h1000);
        check("prio_credits_zero", credits_out, 0);
        check("prio_outstanding", outstanding_out, 8);
        cycle();
        settle();
        check("prio_idle_cmd_valid", command_valid, 0);
        check("prio_idle_pop", req_pop, 0);

        // Round-robin with a WED interjection that must not move the pointer
        do_reset();
        start_job(8'd16);
        for (int i = 0; i < 9; i++) begin
            req_valid = rr_req[i];
            settle();
            check("rr_pop", req_pop, rr_pop[i]);
            if (i > 0) begin
                check("rr_tag", command_out.tag, 64'(i - 1));
                check("rr_addr", command_out.address, rr_addr[i-1]);
            end
            cycle();
        end
        req_valid = '0;
        settle();
        check("rr_last_tag", command_out.tag, 8);
        check("rr_last_addr", command_out.address, rr_addr[8]);
        check("rr_credits", credits_out, 7);
        check("rr_outstanding", outstanding_out, 9);

        // Credit return: +1 two cycles after each issue
        do_reset();
        start_job(8'd2);
        req_valid     = 5'b00010;
        model_credits = 2;
        for (int n = 0; n < 14; n++) begin
            resp_now         = (n >= 2) ? pop_hist[n-2] : 1'b0;
            response_valid   = resp_now;
            response_credits = 9'sd1;
            response_tag     = 8'(n);
            settle();
            exp_pop = (model_credits > 0);
            check("ret_pop", req_pop, exp_pop ? 5'b00010 : 5'b00000);
            check("ret_credits", credits_out, 64'(model_credits));
            pop_hist[n]   = exp_pop;
            model_credits = model_credits - int'(exp_pop) + int'(resp_now);
            cycle();
        end
        response_valid = 1'b0;
        req_valid      = '0;
        settle();
        check("ret_no_error", credit_overflow_error, 0);

        // Simultaneous grant and response, ignored response, overflow
        do_reset();
        start_job(8'd4);
        req_valid = 5'b00010;
        settle();
        check("sim_first_pop", req_pop, 5'b00010);
        cycle();
        response_valid   = 1'b1;
        response_credits = 9'sd1;
        settle();
        check("sim_pop", req_pop, 5'b00010);
        cycle();
        req_valid      = '0;
        response_valid = 1'b0;
        settle();
        check("sim_credits", credits_out, 3);
        check("sim_outstanding", outstanding_out, 1);
        cycle();
        response_valid = 1'b1;
        cycle();
        response_valid = 1'b0;
        settle();
        check("sim_ret_credits", credits_out, 4);
        check("sim_ret_outstanding", outstanding_out, 0);
        cycle();
        response_valid = 1'b1;
        cycle();
        response_valid = 1'b0;
        settle();
        check("ignored_resp_credits", credits_out, 4);
        check("ignored_resp_error", credit_overflow_error, 0);
        cycle();
        req_valid = 5'b00010;
        cycle();
        req_valid        = '0;
        response_valid   = 1'b1;
        response_credits = 9'sd2;
        cycle();
        response_valid = 1'b0;
        settle();
        check("ovf_error", credit_overflow_error, 1);
        check("ovf_credits_sat", credits_out, 4);
        check("ovf_outstanding", outstanding_out, 0);
        cycle();
        cycle();
        settle();
        check("ovf_sticky", credit_overflow_error, 1);
        do_reset();
        check_reset_values("ovf_rst");

        // Drain: enable drops on the third grant, which still issues
        start_job(8'd8);
        req_valid = 5'b00100;
        settle();
        check("drn_pop0", req_pop, 5'b00100);
        cycle();
        settle();
        check("drn_pop1", req_pop, 5'b00100);
        cycle();
        enabled_in = 1'b0;
        settle();
        check("drn_pop_last", req_pop, 5'b00100);
        cycle();
        req_valid = 5'b11111;
        settle();
        check("drn_state", state_out, 3);
        check("drn_no_pop", req_pop, 0);
        check("drn_outstanding", outstanding_out, 3);
        check("drn_last_issue", command_valid, 1);
        cycle();
        response_credits = 9'sd1;
        for (int r = 0; r < 3; r++) begin
            response_valid = 1'b1;
            settle();
            check("drn_resp_state", state_out, 3);
            check("drn_resp_pop", req_pop, 0);
            cycle();
        end
        response_valid = 1'b0;
        settle();
        check("drn_empty_outstanding", outstanding_out, 0);
        check("drn_empty_state", state_out, 3);
        check("drn_credits", credits_out, 8);
        cycle();
        settle();
        check("drn_exit_idle", state_out, 0);
        check("drn_idle_pop", req_pop, 0);

        // Repeat, then reset in the middle of DRAIN
        req_valid = 5'b00100;
        start_job(8'd8);
        cycle();
        cycle();
        enabled_in = 1'b0;
        cycle();
        req_valid      = 5'b11111;
        response_valid = 1'b1;
        settle();
        check("rd_state", state_out, 3);
        check("rd_outstanding", outstanding_out, 3);
        cycle();
        response_valid = 1'b0;
        reset          = 1'b1;
        settle();
        check("rd_pop_in_reset", req_pop, 0);
        cycle();
        reset = 1'b0;
        check_reset_values("rd");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
